// File: rtl/ballot_pkg.sv
// Shared types and helpers for the ballot counter: FSM state encoding,
// mode switch constants and a width-parameterised saturating increment.
package ballot_pkg;

   typedef enum logic [1:0] {
      READY  = 2'd0,
      ACK    = 2'd1,
      LOCKED = 2'd2
   } state_t;

   localparam logic MODE_VOTE   = 1'b0;
   localparam logic MODE_RESULT = 1'b1;

   // Adds one to v unless v already holds the largest w-bit value.
   function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
      logic [31:0] max_v;
      max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      return (v >= max_v) ? max_v : v + 32'd1;
   endfunction

endpackage

// File: rtl/ballot_debounce.sv
// One button channel: 2-FF synchroniser, stability counter, debounced level
// (held) and a single-cycle press pulse on each accepted rising level.
module ballot_debounce
   import ballot_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
   input  logic clock,
   input  logic reset,
   input  logic raw,
   output logic press,
   output logic held
);

   localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

   logic          sync_a;
   logic          sync_b;
   logic [CW-1:0] stable_cnt;

   // The counter runs only while the synchronised input disagrees with the
   // accepted level; any agreement restarts the stability window.
   always_ff @(posedge clock) begin
      if (reset) begin
         sync_a     <= 1'b0;
         sync_b     <= 1'b0;
         stable_cnt <= '0;
         held       <= 1'b0;
         press      <= 1'b0;
      end else begin
         sync_a <= raw;
         sync_b <= sync_a;
         press  <= 1'b0;
         if (sync_b == held) begin
            stable_cnt <= '0;
         end else if (stable_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            stable_cnt <= '0;
            held       <= sync_b;
            press      <= sync_b;
         end else begin
            stable_cnt <= stable_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/ballot_counter_n.sv
// NUM_CAND-candidate voting machine with debounced buttons, one-vote lockout,
// saturating tallies and an LED display. Optional BALLOT_WINNER_EN adds
// registered winner/tie outputs and shows the winner in idle result mode.
module ballot_counter_n
   import ballot_pkg::*;
#(
   parameter int unsigned NUM_CAND        = 4,
   parameter int unsigned CNT_W           = 8,
   parameter int unsigned LED_W           = 8,
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned ACK_CYCLES      = 10000000
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      mode,
   input  logic [NUM_CAND-1:0]       button,
   input  logic                      next_voter,
   output logic [LED_W-1:0]          led,
   output logic                      ready,
   output logic                      vote_reject,
`ifdef BALLOT_WINNER_EN
   output logic [$clog2(NUM_CAND)-1:0] winner,
   output logic                      tie,
`endif
   output logic [NUM_CAND*CNT_W-1:0] tally
);

   localparam int unsigned AW = (ACK_CYCLES > 1) ? $clog2(ACK_CYCLES) : 1;

   logic [NUM_CAND-1:0] press;
   logic [NUM_CAND-1:0] held;
   logic [CNT_W-1:0]    tally_q [NUM_CAND];

   state_t        state;
   state_t        state_d;
   logic [AW-1:0] ack_cnt;
   logic          accept;
   logic          reject;
   logic [CNT_W-1:0] sel_val;
   logic [LED_W-1:0] led_d;

   for (genvar i = 0; i < NUM_CAND; i++) begin : g_btn
      ballot_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
         .clock (clock),
         .reset (reset),
         .raw   (button[i]),
         .press (press[i]),
         .held  (held[i])
      );
      assign tally[i*CNT_W +: CNT_W] = tally_q[i];
   end

   // A vote counts only from READY in voting mode with a single press;
   // every other press is refused.
   assign accept = (state == READY) && (mode == MODE_VOTE) && $onehot(press);
   assign reject = (press != '0) && !accept;
   assign ready  = (state == READY);

   always_comb begin
      state_d = state;
      case (state)
         READY:   if (accept) state_d = ACK;
         ACK:     if (mode == MODE_RESULT || ack_cnt == AW'(ACK_CYCLES - 1)) state_d = LOCKED;
         LOCKED:  if (next_voter) state_d = READY;
         default: state_d = READY;
      endcase
   end

`ifdef BALLOT_WINNER_EN
   logic [$clog2(NUM_CAND)-1:0] win_d;
   logic [CNT_W-1:0]            best_val;
   logic                        tie_d;

   always_comb begin
      win_d    = '0;
      best_val = tally_q[0];
      tie_d    = 1'b0;
      for (int i = 1; i < NUM_CAND; i++) begin
         if (tally_q[i] > best_val) begin
            best_val = tally_q[i];
            win_d    = ($clog2(NUM_CAND))'(i);
         end
      end
      for (int i = 0; i < NUM_CAND; i++) begin
         if (tally_q[i] == best_val && win_d != ($clog2(NUM_CAND))'(i)) tie_d = 1'b1;
      end
      if (best_val == '0) tie_d = 1'b0;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         winner <= '0;
         tie    <= 1'b0;
      end else begin
         winner <= win_d;
         tie    <= tie_d;
      end
   end
`endif

   // Lowest-index held button wins the display; the loop runs downwards so
   // the last assignment is the lowest index.
   always_comb begin
`ifdef BALLOT_WINNER_EN
      sel_val = tally_q[winner];
`else
      sel_val = '0;
`endif
      for (int i = NUM_CAND - 1; i >= 0; i--) begin
         if (held[i]) sel_val = tally_q[i];
      end
      led_d = '0;
      if (state_d == ACK)           led_d = '1;
      else if (mode == MODE_RESULT) led_d = LED_W'(sel_val);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= READY;
         ack_cnt     <= '0;
         led         <= '0;
         vote_reject <= 1'b0;
         for (int i = 0; i < NUM_CAND; i++) tally_q[i] <= '0;
      end else begin
         state       <= state_d;
         led         <= led_d;
         vote_reject <= reject;
         ack_cnt     <= (state == ACK) ? ack_cnt + 1'b1 : '0;
         for (int i = 0; i < NUM_CAND; i++) begin
            if (accept && press[i]) tally_q[i] <= CNT_W'(sat_inc(32'(tally_q[i]), CNT_W));
         end
      end
   end

endmodule

// File: tb/tb_ballot_counter_n.sv
// Directed bench for ballot_counter_n (NUM_CAND=4, CNT_W=4, DEBOUNCE=4, ACK=8).
// Build with BALLOT_WINNER_EN defined to also cover winner/tie.
module tb_ballot_counter_n;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       mode = 1'b0;
   logic [3:0] button = '0;
   logic       next_voter = 1'b0;
   logic [7:0] led;
   logic       ready;
   logic       vote_reject;
   logic [15:0] tally;
`ifdef BALLOT_WINNER_EN
   logic [1:0] winner;
   logic       tie;
`endif

   int checks = 0;
   int errors = 0;
   int rej_cnt = 0;
   int ack_seen = 0;

   ballot_counter_n #(
      .NUM_CAND(4), .CNT_W(4), .LED_W(8), .DEBOUNCE_CYCLES(4), .ACK_CYCLES(8)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .mode        (mode),
      .button      (button),
      .next_voter  (next_voter),
      .led         (led),
      .ready       (ready),
      .vote_reject (vote_reject),
`ifdef BALLOT_WINNER_EN
      .winner      (winner),
      .tie         (tie),
`endif
      .tally       (tally)
   );

   always #5 clock = ~clock;

   always @(negedge clock) begin
      if (vote_reject) rej_cnt++;
      if (led == 8'hFF && mode == 1'b0) ack_seen++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] get_tally(input int idx);
      return tally[idx*4 +: 4];
   endfunction

   task automatic hold_buttons(input logic [3:0] mask, input int n);
      button = mask;
      repeat (n) @(negedge clock);
      button = '0;
      repeat (12) @(negedge clock);
   endtask

   task automatic pulse_next();
      next_voter = 1'b1;
      @(negedge clock);
      next_voter = 1'b0;
   endtask

   task automatic do_vote(input int idx);
      hold_buttons(4'(1 << idx), 20);
      pulse_next();
   endtask

   initial begin
      int r0, a0, t;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      check("rst_led", led, 8'h00);
      check("rst_ready", ready, 1);
      check("rst_reject", vote_reject, 0);
      check("rst_tally", tally, 16'h0000);

      // clean vote on candidate 2, then a refused second press
      r0 = rej_cnt; a0 = ack_seen;
      hold_buttons(4'b0100, 20);
      check("vote_tally2", get_tally(2), 1);
      check("vote_ack_len", ack_seen - a0, 8);
      check("vote_locked", ready, 0);
      check("vote_no_rej", rej_cnt - r0, 0);
      hold_buttons(4'b0100, 10);
      check("locked_rej", rej_cnt - r0, 1);
      check("locked_tally2", get_tally(2), 1);
      pulse_next();
      check("next_ready", ready, 1);

      // bouncing input must not register
      r0 = rej_cnt;
      for (int k = 0; k < 5; k++) begin
         button = 4'b0001;
         repeat (2) @(negedge clock);
         button = 4'b0000;
         repeat (2) @(negedge clock);
      end
      repeat (8) @(negedge clock);
      check("bounce_tally0", get_tally(0), 0);
      check("bounce_ready", ready, 1);
      check("bounce_rej", rej_cnt - r0, 0);
      hold_buttons(4'b0001, 20);
      check("held_tally0", get_tally(0), 1);
      pulse_next();
      check("next_ready2", ready, 1);

      // simultaneous presses are refused
      r0 = rej_cnt; a0 = ack_seen;
      hold_buttons(4'b1010, 20);
      check("dual_rej", rej_cnt - r0, 1);
      check("dual_tallies", tally, 16'h0101);
      check("dual_ready", ready, 1);
      check("dual_no_ack", ack_seen - a0, 0);

      // saturation on candidate 3
      for (int v = 0; v < 16; v++) do_vote(3);
      check("sat_tally3", get_tally(3), 15);
      a0 = ack_seen;
      hold_buttons(4'b1000, 20);
      check("sat_ack_len", ack_seen - a0, 8);
      check("sat_hold3", get_tally(3), 15);
      pulse_next();
      check("sat_ready", ready, 1);

      // reset during the third ACK clock
      button = 4'b0100;
      t = 0;
      while (ready && t < 50) begin
         @(negedge clock);
         t++;
      end
      check("midack_entry", ready, 0);
      repeat (2) @(negedge clock);
      check("midack_led", led, 8'hFF);
      reset = 1'b1;
      button = 4'b0000;
      @(negedge clock);
      check("midack_rst_led", led, 8'h00);
      check("midack_rst_ready", ready, 1);
      check("midack_rst_tally", tally, 16'h0000);
      reset = 1'b0;
      repeat (12) @(negedge clock);
      check("midack_no_vote", tally, 16'h0000);

      // result mode display
      do_vote(0); do_vote(0);
      for (int v = 0; v < 5; v++) do_vote(1);
      check("res_tallies", tally, 16'h0052);
      r0 = rej_cnt;
      mode = 1'b1;
      button = 4'b0010;
      repeat (10) @(negedge clock);
      check("res_led_b1", led, 8'h05);
      button = 4'b0011;
      repeat (10) @(negedge clock);
      check("res_led_b01", led, 8'h02);
      button = 4'b0000;
      repeat (12) @(negedge clock);
`ifdef BALLOT_WINNER_EN
      check("res_led_none", led, 8'h05);
      check("winner", winner, 1);
      check("tie", tie, 0);
`else
      check("res_led_none", led, 8'h00);
`endif
      check("res_mode_rej", rej_cnt - r0, 2);
      check("res_tally_keep", tally, 16'h0052);
      mode = 1'b0;
      repeat (2) @(negedge clock);
      check("vote_mode_led", led, 8'h00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
